// File: rtl/uc_pkg.sv
// Shared definitions for the SRAM DMA controller: FSM state encoding and command opcodes.
package uc_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RD   = 2'd1,
    ST_WR   = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  localparam logic OP_FILL = 1'b0;
  localparam logic OP_COPY = 1'b1;

endpackage

// File: rtl/sram_dma_ctrl_if.sv
// Point-to-point SRAM bus between the DMA controller (master) and a sram_256x8-style memory (slave).
interface sram_dma_ctrl_if #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8
);
  logic              sram_write_en;
  logic [ADDR_W-1:0] sram_addr;
  logic [DATA_W-1:0] sram_data_out;
  logic [DATA_W-1:0] sram_data_in;

  modport master (
    output sram_write_en,
    output sram_addr,
    output sram_data_out,
    input  sram_data_in
  );

  modport slave (
    input  sram_write_en,
    input  sram_addr,
    input  sram_data_out,
    output sram_data_in
  );
endinterface

// File: rtl/sram_dma_ctrl.sv
// FILL/COPY DMA engine for a single-port async-read SRAM; one byte per WR cycle,
// COPY interleaves a RD cycle before every write so overlapping ranges behave byte-serially.
module sram_dma_ctrl
  import uc_pkg::*;
#(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              arst,
  input  logic              clk_valid,
  input  logic              start,
  input  logic              op,
  input  logic [ADDR_W-1:0] src_addr,
  input  logic [ADDR_W-1:0] dst_addr,
  input  logic [ADDR_W-1:0] len,
  input  logic [DATA_W-1:0] fill_data,
  input  logic              abort,
  output logic              busy,
  output logic              done,
  output logic              aborted,
  output logic [DATA_W-1:0] checksum,
  sram_dma_ctrl_if.master   sram
);

  state_t            r_state;
  state_t            w_state_nxt;
  logic [ADDR_W-1:0] r_src;
  logic [ADDR_W-1:0] r_dst;
  logic [ADDR_W-1:0] r_remain;
  logic [DATA_W-1:0] r_buf;
  logic [DATA_W-1:0] r_fill;
  logic              r_op;
  logic              r_aborted;
  logic [DATA_W-1:0] r_checksum;

  logic              w_last;
  logic [DATA_W-1:0] w_wdata;
  logic              w_busy;
  logic              w_done;
  logic              w_we;
  logic [ADDR_W-1:0] w_addr;
  logic [DATA_W-1:0] w_dout;

  assign w_last  = (r_remain == ADDR_W'(1));
  assign w_wdata = (r_op == OP_COPY) ? r_buf : r_fill;

  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_busy      = 1'b1;
    w_done      = 1'b0;
    w_we        = 1'b0;
    w_addr      = r_dst;
    w_dout      = '0;
    unique case (r_state)
      ST_IDLE: begin
        w_busy = 1'b0;
        if (clk_valid && start) begin
          if (len == '0)            w_state_nxt = ST_DONE;
          else if (op == OP_COPY)   w_state_nxt = ST_RD;
          else                      w_state_nxt = ST_WR;
        end
      end
      ST_RD: begin
        w_addr = r_src;
        if (clk_valid) w_state_nxt = abort ? ST_DONE : ST_WR;
      end
      ST_WR: begin
        w_we   = 1'b1;
        w_dout = w_wdata;
        if (clk_valid) begin
          if (w_last || abort)      w_state_nxt = ST_DONE;
          else if (r_op == OP_COPY) w_state_nxt = ST_RD;
          else                      w_state_nxt = ST_WR;
        end
      end
      ST_DONE: begin
        w_done = 1'b1;
        if (clk_valid) w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Datapath registers follow the same clk_valid gating as the state register.
  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      r_src      <= '0;
      r_dst      <= '0;
      r_remain   <= '0;
      r_buf      <= '0;
      r_fill     <= '0;
      r_op       <= OP_FILL;
      r_aborted  <= 1'b0;
      r_checksum <= '0;
    end else if (clk_valid) begin
      unique case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_src      <= src_addr;
            r_dst      <= dst_addr;
            r_remain   <= len;
            r_fill     <= fill_data;
            r_op       <= op;
            r_aborted  <= 1'b0;
            r_checksum <= '0;
          end
        end
        ST_RD: begin
          if (abort) r_aborted <= 1'b1;
          else       r_buf     <= sram.sram_data_in;
        end
        ST_WR: begin
          r_checksum <= r_checksum + w_wdata;
          r_src      <= r_src + ADDR_W'(1);
          r_dst      <= r_dst + ADDR_W'(1);
          r_remain   <= r_remain - ADDR_W'(1);
          if (abort) r_aborted <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign busy               = w_busy;
  assign done               = w_done;
  assign aborted            = r_aborted;
  assign checksum           = r_checksum;
  assign sram.sram_write_en = w_we;
  assign sram.sram_addr     = w_addr;
  assign sram.sram_data_out = w_dout;

endmodule

// File: doc/sram_dma_ctrl.md
SRAM_DMA_CTRL -- requirements
Module: sram_dma_ctrl

Interface
REQ-001 Parameter ADDR_W, default 8, SRAM address width; the SRAM has 2^ADDR_W bytes.
REQ-002 Parameter DATA_W, default 8, SRAM data width.
REQ-003 clk  input  1  single system clock; all state changes on its rising edge.
REQ-004 arst  input  1  asynchronous reset, active-high.
REQ-005 clk_valid  input  1  clock enable; the FSM, counters and checksum advance only when it is 1.
REQ-006 start  input  1  command strobe; sampled only in IDLE with clk_valid=1.
REQ-007 op  input  1  command type: 0=FILL, 1=COPY; sampled with start.
REQ-008 src_addr  input  ADDR_W  COPY source base address; sampled with start.
REQ-009 dst_addr  input  ADDR_W  destination base address; sampled with start.
REQ-010 len  input  ADDR_W  byte count; 0 means no transfer.
REQ-011 fill_data  input  DATA_W  FILL byte value; sampled with start.
REQ-012 abort  input  1  request to stop the transfer early.
REQ-013 busy  output  1  high in any state other than IDLE.
REQ-014 done  output  1  one-cycle completion pulse.
REQ-015 aborted  output  1  set when the last command ended by abort; valid while done=1, held until the next start.
REQ-016 checksum  output  DATA_W  modulo-2^DATA_W sum of the bytes written by the last command.
REQ-017 sram_write_en  output  1  SRAM write strobe.
REQ-018 sram_addr  output  ADDR_W  SRAM address.
REQ-019 sram_data_out  output  DATA_W  write data sent to the SRAM.
REQ-020 sram_data_in  input  DATA_W  asynchronous read data returned by the SRAM for sram_addr.

Function
REQ-021 The FSM SHALL have four states: IDLE, RD, WR and DONE.
REQ-022 IDLE transitions on start=1 and clk_valid=1:
- len=0: go to DONE.
- COPY: go to RD.
- FILL: go to WR.
- In all three cases, latch the operands, clear checksum and clear aborted.
REQ-023 RD drives sram_addr=src pointer and sram_write_en=0; on the next clk_valid edge it captures sram_data_in into the byte buffer and goes to WR.
REQ-024 WR drives sram_addr=dst pointer, sram_write_en=1 and sram_data_out=buffer (COPY) or fill_data latch (FILL). On the clk_valid edge it:
- adds sram_data_out to checksum;
- increments both pointers;
- decrements the remaining count.
REQ-025 After WR: remaining count reaching 0 or abort=1 goes to DONE; otherwise COPY goes to RD and FILL goes to WR.
REQ-026 Abort rules:
- abort=1 in RD goes to DONE with no write performed.
- abort=1 in WR completes the current byte write first, then goes to DONE.
- In both cases aborted is set to 1.
REQ-027 DONE asserts done=1 for one clk_valid cycle, then returns to IDLE.
REQ-028 Throughput:
- COPY takes 2 enabled cycles per byte; FILL takes 1.
- done occurs in the enabled cycle after the last write.
REQ-029 Pointers wrap modulo 2^ADDR_W; a transfer crossing address 255 continues at address 0.
REQ-030 len values cover 1..255 bytes; 0 completes after the single DONE cycle with checksum=0 and no writes.
REQ-031 Overlap is defined behaviour: each byte is read then written in strictly ascending order, so COPY with dst=src+1 replicates the src byte across the range.
REQ-032 start while busy SHALL be ignored, with no effect on the running transfer.
REQ-033 With clk_valid=0, all registers hold and outputs stay stable; sram_write_en remains asserted in WR, and the SRAM gates its write with the same clk_valid.
REQ-034 Outside WR, sram_write_en=0; in IDLE and DONE, sram_addr=dst pointer and sram_data_out=0.

Reset
REQ-035 arst=1 SHALL immediately force:
- state=IDLE;
- busy=0, done=0, aborted=0, checksum=0;
- sram_write_en=0, sram_addr=0, sram_data_out=0;
- pointers, remaining count and buffer cleared.
REQ-036 Reset mid-transfer abandons the command without done; bytes already written stay written, and the next command starts clean.

Structure
REQ-037 State encoding and the op constants (OP_FILL, OP_COPY) SHALL live in the shared package uc_pkg.
REQ-038 The block SHALL be one flat module with no sub-module; it connects point-to-point to sram_256x8-compatible ports.

Verification
REQ-039 FILL dst=0xFE, len=4, fill_data=0xA5 -> writes to 0xFE,0xFF,0x00,0x01; 4 write cycles; checksum=0x94; done one cycle later.
REQ-040 COPY src=0x10, dst=0x80, len=3, bytes 01,02,03 -> mem[0x80..0x82]=01,02,03; 6 enabled cycles; checksum=0x06.
REQ-041 COPY src=0x20, dst=0x21, len=3, mem[0x20]=0x5A -> mem[0x21..0x23]=5A.
REQ-042 len=0 -> no sram_write_en pulse; done two cycles after start; checksum=0.
REQ-043 FILL len=10, abort asserted in the 3rd WR cycle -> exactly 3 bytes written; done=1 with aborted=1; start pulses during busy ignored.
REQ-044 clk_valid toggling 1/0 during COPY len=2 -> same memory result, cycle count doubled; arst pulse mid-transfer -> outputs zero immediately, no done.
